// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the IF/ID/IX/IM/IW pipeline: stage hold/bubble/flush sequencing and IX operand forwarding.
// Optional feature macro: HAZARD_FWD_EN (forwarding + load-use-only stalls); undefined = interlock on every RAW.
module hazard_stall_ctrl #(
    parameter int RA_W        = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic [RA_W-1:0] ix_rs,
    input  logic [RA_W-1:0] ix_rt,
    input  logic [RA_W-1:0] ix_dest,
    input  logic            ix_wr,
    input  logic            ix_load,
    input  logic [RA_W-1:0] im_dest,
    input  logic            im_wr,
    input  logic [RA_W-1:0] iw_dest,
    input  logic            iw_wr,
    input  logic            im_update_pc,
    input  logic            dmem_req,
    input  logic            dmem_ack,
    output logic            pc_hold,
    output logic            ifid_hold,
    output logic            idix_bubble,
    output logic            ixim_hold,
    output logic            imiw_bubble,
    output logic            flush,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel,
    output logic [1:0]      state,
    output logic            mem_timeout
);

    typedef enum logic [1:0] {
        S_RUN     = 2'b00,
        S_STALL   = 2'b01,
        S_MEMWAIT = 2'b10,
        S_FLUSH   = 2'b11
    } state_e;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_flush_q, pend_flush_d;
    logic       mem_timeout_q, mem_timeout_d;

    logic       memwait, do_flush, hazard, stall;
    logic [1:0] fwd_a, fwd_b;

    // r0 is hardwired zero, so it never creates a dependency
    function automatic logic hit(input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

`ifdef HAZARD_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] s, input logic [RA_W-1:0] imd,
                                           input logic imw, input logic [RA_W-1:0] iwd, input logic iww);
        if (imw && hit(s, imd)) return 2'b01;
        if (iww && hit(s, iwd)) return 2'b10;
        return 2'b00;
    endfunction

    assign hazard = ix_load & ix_wr & ((id_uses_rs & hit(id_rs, ix_dest)) |
                                       (id_uses_rt & hit(id_rt, ix_dest)));
    assign fwd_a  = fwd_sel(ix_rs, im_dest, im_wr, iw_dest, iw_wr);
    assign fwd_b  = fwd_sel(ix_rt, im_dest, im_wr, iw_dest, iw_wr);
`else
    function automatic logic dep(input logic [RA_W-1:0] s,
                                 input logic [RA_W-1:0] xd, input logic xw,
                                 input logic [RA_W-1:0] md, input logic mw,
                                 input logic [RA_W-1:0] wd, input logic ww);
        return (xw & hit(s, xd)) | (mw & hit(s, md)) | (ww & hit(s, wd));
    endfunction

    // Without bypass paths the consumer waits in ID until its producer has retired
    assign hazard = (id_uses_rs & dep(id_rs, ix_dest, ix_wr, im_dest, im_wr, iw_dest, iw_wr)) |
                    (id_uses_rt & dep(id_rt, ix_dest, ix_wr, im_dest, im_wr, iw_dest, iw_wr));
    assign fwd_a  = 2'b00;
    assign fwd_b  = 2'b00;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ix_rs, ix_rt, ix_load};
`endif

    always_comb begin
        state_d       = S_RUN;
        cnt_d         = 8'd0;
        pend_flush_d  = pend_flush_q;
        mem_timeout_d = mem_timeout_q;

        memwait  = dmem_req & ~dmem_ack;
        do_flush = (im_update_pc | pend_flush_q) & ~memwait;
        stall    = hazard & ~memwait & ~do_flush;

        if (memwait) begin
            state_d      = S_MEMWAIT;
            cnt_d        = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            // A redirect resolved during the wait must survive until the wait ends
            pend_flush_d = pend_flush_q | im_update_pc;
            if (cnt_d == TMO) mem_timeout_d = 1'b1;
        end else if (do_flush) begin
            state_d      = S_FLUSH;
            pend_flush_d = 1'b0;
        end else if (stall) begin
            state_d      = S_STALL;
        end

        // Held quiet while reset is asserted, whatever the stage inputs show
        pc_hold     = rst_n & (memwait | stall);
        ifid_hold   = rst_n & (memwait | stall);
        idix_bubble = rst_n & stall;
        ixim_hold   = rst_n & memwait;
        imiw_bubble = rst_n & memwait;
        flush       = rst_n & do_flush;
        fwd_a_sel   = rst_n ? fwd_a : 2'b00;
        fwd_b_sel   = rst_n ? fwd_b : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RUN;
            cnt_q         <= 8'd0;
            pend_flush_q  <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_flush_q  <= pend_flush_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign state       = state_q;
    assign mem_timeout = mem_timeout_q;

endmodule
